rgb_luma_stats: RTL

- Downstream consumer of the demosaic stage's RGB stream (valid + 8-bit R/G/B).
- Produces a pipelined 8-bit luma (gray) stream, tagged with start-of-frame, end-of-line and end-of-frame flags.
- Accumulates per-frame luma statistics (sum, min, max) and publishes them once per frame.
- Feeds exposure control and any gray-scale display/processing path.

---
 rtl/rgb_luma_stats_if.sv | 28 ++
 rtl/rgb_luma_stats.sv | 101 ++++++++++
 2 files changed

// File: rtl/rgb_luma_stats_if.sv
// rgb_luma_stats_if: RGB input stream, luma output stream and frame statistics bundle
interface rgb_luma_stats_if #(
  parameter int SUM_W = 26
);
  logic soft_clr;
  logic rgb_valid;
  logic [7:0] r_in;
  logic [7:0] g_in;
  logic [7:0] b_in;
  logic y_valid;
  logic [7:0] y_out;
  logic y_sof;
  logic y_eol;
  logic y_eof;
  logic stat_valid;
  logic [SUM_W-1:0] stat_sum;
  logic [7:0] stat_min;
  logic [7:0] stat_max;
  logic [15:0] frame_cnt;
  modport master (
    output soft_clr, rgb_valid, r_in, g_in, b_in,
    input y_valid, y_out, y_sof, y_eol, y_eof, stat_valid, stat_sum, stat_min, stat_max, frame_cnt
  );
  modport slave (
    input soft_clr, rgb_valid, r_in, g_in, b_in,
    output y_valid, y_out, y_sof, y_eol, y_eof, stat_valid, stat_sum, stat_min, stat_max, frame_cnt
  );
endinterface

// File: rtl/rgb_luma_stats.sv
// rgb_luma_stats: 3-stage RGB-to-luma pipeline with frame tagging and per-frame sum/min/max
module rgb_luma_stats #(
  parameter int IMAGE_WIDTH = 320,
  parameter int IMAGE_HEIGHT = 466,
  parameter int SUM_W = 26
) (
  input logic clk,
  input logic rst_n,
  rgb_luma_stats_if.slave bus
);
  localparam int XW = $clog2(IMAGE_WIDTH + 1);
  localparam int YW = $clog2(IMAGE_HEIGHT + 1);
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic s1_v, s2_v;
  logic [2:0] s1_f, s2_f;
  logic [15:0] s1_pr, s1_pg, s1_pb;
  logic [16:0] s2_sum;
  logic [SUM_W-1:0] run_sum, nsum;
  logic [7:0] run_min, run_max, nmin, nmax, yc;
  logic last_x, last_y;
  assign last_x = x == XW'(IMAGE_WIDTH - 1);
  assign last_y = y == YW'(IMAGE_HEIGHT - 1);
  assign yc = s2_sum[16] ? 8'hff : s2_sum[15:8];
  assign nsum = bus.y_sof ? SUM_W'(bus.y_out) : run_sum + SUM_W'(bus.y_out);
  assign nmin = (bus.y_sof || bus.y_out < run_min) ? bus.y_out : run_min;
  assign nmax = (bus.y_sof || bus.y_out > run_max) ? bus.y_out : run_max;
  // position tracking and the products / rounded sum / shift-and-clamp stages
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x <= '0;
      y <= '0;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_f <= '0;
      s2_f <= '0;
      s1_pr <= '0;
      s1_pg <= '0;
      s1_pb <= '0;
      s2_sum <= '0;
      bus.y_valid <= 1'b0;
      bus.y_out <= '0;
      {bus.y_sof, bus.y_eol, bus.y_eof} <= 3'b0;
    end else if (bus.soft_clr) begin
      x <= '0;
      y <= '0;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_f <= '0;
      s2_f <= '0;
      bus.y_valid <= 1'b0;
      bus.y_out <= '0;
      {bus.y_sof, bus.y_eol, bus.y_eof} <= 3'b0;
    end else begin
      if (bus.rgb_valid) begin
        x <= last_x ? '0 : x + XW'(1);
        if (last_x) y <= last_y ? '0 : y + YW'(1);
      end
      s1_v <= bus.rgb_valid;
      s1_f <= bus.rgb_valid ? {x == '0 && y == '0, last_x, last_x && last_y} : 3'b0;
      s1_pr <= 16'(bus.r_in) * 16'd77;
      s1_pg <= 16'(bus.g_in) * 16'd150;
      s1_pb <= 16'(bus.b_in) * 16'd29;
      s2_v <= s1_v;
      s2_f <= s1_f;
      s2_sum <= 17'(s1_pr) + 17'(s1_pg) + 17'(s1_pb) + 17'd128;
      bus.y_valid <= s2_v;
      bus.y_out <= s2_v ? yc : 8'd0;
      {bus.y_sof, bus.y_eol, bus.y_eof} <= s2_f;
    end
  // running frame statistics, published on the cycle after the end-of-frame pixel
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run_sum <= '0;
      run_min <= 8'hff;
      run_max <= '0;
      bus.stat_valid <= 1'b0;
      bus.stat_sum <= '0;
      bus.stat_min <= '0;
      bus.stat_max <= '0;
      bus.frame_cnt <= '0;
    end else if (bus.soft_clr) begin
      run_sum <= '0;
      run_min <= 8'hff;
      run_max <= '0;
      bus.stat_valid <= 1'b0;
    end else begin
      bus.stat_valid <= bus.y_valid && bus.y_eof;
      if (bus.y_valid) begin
        run_sum <= nsum;
        run_min <= nmin;
        run_max <= nmax;
      end
      if (bus.y_valid && bus.y_eof) begin
        bus.stat_sum <= nsum;
        bus.stat_min <= nmin;
        bus.stat_max <= nmax;
        bus.frame_cnt <= bus.frame_cnt + 16'd1;
      end
    end
endmodule
